// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants used by the register file, decode and hazard logic
package regfile_pkg;
  localparam int REGFILE_DATA_W   = 32;
  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_ZERO_IDX = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits set on long-latency issue, cleared by port-1 writeback
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] busy
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] busy_q, busy_d;
  // issue applied after clear: the newer op owns the register
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (issue_en) busy_d[issue_addr] = 1'b1;
    if (ZERO_REG) busy_d[REGFILE_ZERO_IDX] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign busy = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, two-write register file with optional same-cycle bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_READ = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*ADDR_W-1:0] raddr,
  output logic [NUM_READ*DATA_W-1:0] rdata,
  output logic [NUM_READ-1:0]        rbusy,
  input  logic                       wen0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       wen1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(REGFILE_ZERO_IDX);
  logic [DATA_W-1:0] store_q [DEPTH];
  logic [DATA_W-1:0] store_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              byp_en;
  logic              we0, we1;
  assign we0    = wen0 && !(ZERO_REG && waddr0 == ZIDX);
  assign we1    = wen1 && !(ZERO_REG && waddr1 == ZIDX);
  assign byp_en = BYPASS && !rst;
  // port 1 written last so it wins a same-index collision
  always_comb begin
    store_d = store_q;
    if (we0) store_d[waddr0] = wdata0;
    if (we1) store_d[waddr1] = wdata1;
  end
  always_ff @(posedge clk) begin
    if (rst) store_q <= '{default: '0};
    else store_q <= store_d;
  end
  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .clr_en    (wen1),
    .clr_addr  (waddr1),
    .busy      (busy)
  );
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero, hit0, hit1;
    assign ra   = raddr[k*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG && ra == ZIDX;
    assign hit1 = byp_en && wen1 && waddr1 == ra;
    assign hit0 = byp_en && wen0 && waddr0 == ra;
    assign rdata[k*DATA_W +: DATA_W] = zero ? '0 : hit1 ? wdata1 : hit0 ? wdata0 : store_q[ra];
    assign rbusy[k] = zero ? 1'b0 : hit1 ? (issue_en && issue_addr == ra) : busy[ra];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector bench driving a bypass and a non-bypass register file in parallel
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst, wen0, wen1, issue_en;
  logic [4:0]  waddr0, waddr1, issue_addr, ra0, ra1;
  logic [31:0] wdata0, wdata1;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  regfile_mp #(.BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .raddr({ra1, ra0}), .rdata(rdata_a), .rbusy(rbusy_a),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );
  regfile_mp #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .raddr({ra1, ra0}), .rdata(rdata_b), .rbusy(rbusy_b),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );
  typedef struct {
    logic rst; logic wen0; logic [4:0] wa0; logic [31:0] wd0;
    logic wen1; logic [4:0] wa1; logic [31:0] wd1;
    logic iss; logic [4:0] ia; logic [4:0] ra0; logic [4:0] ra1;
    logic [31:0] e0; logic [31:0] e1; logic [1:0] eb;
    logic [31:0] n0; logic [31:0] n1; logic [1:0] nb;
  } vec_t;
  vec_t vecs [18];
  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; wen0 = v.wen0; waddr0 = v.wa0; wdata0 = v.wd0;
    wen1 = v.wen1; waddr1 = v.wa1; wdata1 = v.wd1;
    issue_en = v.iss; issue_addr = v.ia; ra0 = v.ra0; ra1 = v.ra1;
  endtask
  task automatic check(input string name, input vec_t v);
    @(negedge clk);
    n_vec++;
    if ({rdata_a[63:32], rdata_a[31:0], rbusy_a} !== {v.e1, v.e0, v.eb}) begin
      n_bad++;
      $display("FAIL %s bypass: got d0=%h d1=%h busy=%b, want d0=%h d1=%h busy=%b",
               name, rdata_a[31:0], rdata_a[63:32], rbusy_a, v.e0, v.e1, v.eb);
    end
    n_vec++;
    if ({rdata_b[63:32], rdata_b[31:0], rbusy_b} !== {v.n1, v.n0, v.nb}) begin
      n_bad++;
      $display("FAIL %s nobypass: got d0=%h d1=%h busy=%b, want d0=%h d1=%h busy=%b",
               name, rdata_b[31:0], rdata_b[63:32], rbusy_b, v.n0, v.n1, v.nb);
    end
  endtask
  function automatic vec_t idle(input logic [4:0] a0, input logic [4:0] a1);
    vec_t v;
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a0, a1,
          32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
    return v;
  endfunction
  initial begin
    vec_t v;
    //            rst  w0   wa0  wd0            w1   wa1  wd1        iss  ia   ra0  ra1  e0             e1             eb     n0             n1             nb
    vecs[0]  = '{1'b0,1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd5, 5'd9, 32'hDEADBEEF,32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
    vecs[1]  = '{1'b0,1'b1,5'd0, 32'h1234,    1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd5, 5'd0, 32'hDEADBEEF,32'h0,        2'b00, 32'hDEADBEEF,32'h0,        2'b00};
    vecs[2]  = '{1'b0,1'b1,5'd9, 32'hA5,      1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd0, 5'd9, 32'h0,       32'hA5,       2'b00, 32'h0,        32'h0,        2'b00};
    vecs[3]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd9, 5'd5, 32'hA5,      32'hDEADBEEF, 2'b00, 32'hA5,       32'hDEADBEEF, 2'b00};
    vecs[4]  = '{1'b0,1'b1,5'd3, 32'h11,      1'b1,5'd3, 32'h22,   1'b0,5'd0, 5'd3, 5'd3, 32'h22,      32'h22,       2'b00, 32'h0,        32'h0,        2'b00};
    vecs[5]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b1,5'd12,5'd3, 5'd12,32'h22,      32'h0,        2'b00, 32'h22,       32'h0,        2'b00};
    vecs[6]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd12,5'd3, 32'h0,       32'h22,       2'b01, 32'h0,        32'h22,       2'b01};
    vecs[7]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd12,32'h77,   1'b0,5'd0, 5'd12,5'd12,32'h77,      32'h77,       2'b00, 32'h0,        32'h0,        2'b11};
    vecs[8]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd12,5'd5, 32'h77,      32'hDEADBEEF, 2'b00, 32'h77,       32'hDEADBEEF, 2'b00};
    vecs[9]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b1,5'd12,5'd12,5'd12,32'h77,      32'h77,       2'b00, 32'h77,       32'h77,       2'b00};
    vecs[10] = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd12,32'h88,   1'b1,5'd12,5'd12,5'd12,32'h88,      32'h88,       2'b11, 32'h77,       32'h77,       2'b11};
    vecs[11] = '{1'b0,1'b1,5'd12,32'h55,      1'b0,5'd0, 32'h0,    1'b1,5'd0, 5'd12,5'd0, 32'h55,      32'h0,        2'b01, 32'h88,       32'h0,        2'b01};
    vecs[12] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd12,5'd0, 32'h55,      32'h0,        2'b01, 32'h55,       32'h0,        2'b01};
    vecs[13] = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0, 32'hFFFF, 1'b1,5'd0, 5'd0, 5'd12,32'h0,       32'h55,       2'b10, 32'h0,        32'h55,       2'b10};
    vecs[14] = '{1'b0,1'b1,5'd7, 32'h42,      1'b1,5'd12,32'h66,   1'b0,5'd0, 5'd7, 5'd12,32'h42,      32'h66,       2'b00, 32'h0,        32'h55,       2'b10};
    vecs[15] = '{1'b1,1'b1,5'd7, 32'h1111,    1'b0,5'd0, 32'h0,    1'b1,5'd4, 5'd7, 5'd12,32'h42,      32'h66,       2'b00, 32'h42,       32'h66,       2'b00};
    vecs[16] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd7, 5'd12,32'h0,       32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
    vecs[17] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,    1'b0,5'd0, 5'd5, 5'd4, 32'h0,       32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
    v = idle(5'd0, 5'd0);
    v.rst = 1'b1;
    drive(v);
    drive(v);
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i]);
    end
    // busy persists across idle cycles until the port-1 writeback clears it
    v = idle(5'd20, 5'd0);
    v.iss = 1'b1; v.ia = 5'd20;
    drive(v);
    check("issue20", v);
    for (int c = 0; c < 3; c++) begin
      v = idle(5'd20, 5'd0);
      v.eb = 2'b01; v.nb = 2'b01;
      drive(v);
      check($sformatf("hold20_%0d", c), v);
    end
    v = idle(5'd20, 5'd20);
    v.wen1 = 1'b1; v.wa1 = 5'd20; v.wd1 = 32'hABC;
    v.e0 = 32'hABC; v.e1 = 32'hABC; v.eb = 2'b00;
    v.nb = 2'b11;
    drive(v);
    check("wb20", v);
    v = idle(5'd20, 5'd20);
    v.e0 = 32'hABC; v.e1 = 32'hABC; v.n0 = 32'hABC; v.n1 = 32'hABC;
    drive(v);
    check("after20", v);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
